// File: rtl/cdda_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cdda_fifo_pkg
// Shared definitions for the CD-audio playback path: the read-FSM state type
// and the audio constants used as parameter defaults.
// -----------------------------------------------------------------------------
package cdda_fifo_pkg;

  // Red Book CD audio output rate, in stereo sample pairs per second.
  localparam int unsigned CDDA_SAMPLE_HZ    = 44100;

  // One 2352-byte CD sector expressed in 16-bit PCM words.
  localparam int unsigned CDDA_SECTOR_WORDS = 1176;

  // Read FSM: wait for a tick, fetch the left word, fetch the right word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_L = 2'd1,
    RD_R = 2'd2
  } cdda_state_e;

endpackage

// File: rtl/cdda_ram.sv
// -----------------------------------------------------------------------------
// cdda_ram
// Simple dual-port RAM, one write port and one read port, with a registered
// read (data appears one clock after i_re). Written in the plain form that
// synthesis maps onto block RAM.
//
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable; o_rdata updates on the next edge
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module cdda_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array and its read register get no reset; a reset would stop
  // the storage from mapping onto block RAM, and the FIFO count already
  // marks every stale word as invalid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cdda_fifo.sv
// -----------------------------------------------------------------------------
// cdda_fifo
// CD-audio consumer behind the HPS extension decoder. Buffers interleaved
// 16-bit PCM words (L, R, L, R, ...), plays them out as stereo pairs at
// SAMPLE_HZ, and raises cdda_req whenever a full sector of space is free.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   playback enable (0: outputs zero, no pops, no requests)
//   flush      in   synchronous clear of contents, flags and playback state
//   cdda_wr    in   one-cycle write strobe from the HPS
//   cdda_din   in   PCM word accompanying cdda_wr
//   cdda_req   out  more data wanted (registered)
//   left       out  signed left sample
//   right      out  signed right sample
//   sample_ce  out  one-cycle pulse when left/right update
//   underrun   out  sticky: a tick found fewer than two words
//   overflow   out  sticky: a write arrived while full
//   level      out  current word count, 0..2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module cdda_fifo
  import cdda_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 28375160,
  parameter int unsigned SAMPLE_HZ  = CDDA_SAMPLE_HZ,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned REQ_WORDS  = CDDA_SECTOR_WORDS
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  cdda_wr,
  input  logic [15:0]           cdda_din,
  output logic                  cdda_req,
  output logic signed [15:0]    left,
  output logic signed [15:0]    right,
  output logic                  sample_ce,
  output logic                  underrun,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned              DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]      CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]      CNT_TWO = (DEPTH_LOG2 + 1)'(2);
  localparam logic [DEPTH_LOG2-1:0]    PTR_ONE = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2-1:0]    PTR_TWO = (DEPTH_LOG2)'(2);

  // State and datapath registers
  cdda_state_e             r_state;
  cdda_state_e             w_state_next;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [31:0]             r_acc;
  logic [15:0]             r_hold;
  logic [15:0]             r_left;
  logic [15:0]             r_right;
  logic                    r_sample_ce;
  logic                    r_underrun;
  logic                    r_overflow;
  logic                    r_req;

  // Combinational controls
  logic [31:0]             w_acc_sum;
  logic                    w_tick;
  logic                    w_full;
  logic                    w_have_pair;
  logic                    w_wr_accept;
  logic                    w_ram_re;
  logic [DEPTH_LOG2-1:0]   w_ram_raddr;
  logic [15:0]             w_ram_rdata;
  logic                    w_pop;
  logic                    w_hold_load;
  logic                    w_pair_load;
  logic                    w_starve;

  // ---------------------------------------------------------------------------
  // Fractional divider: the accumulator gains SAMPLE_HZ per clock and a tick
  // fires whenever it would reach CLK_HZ, so ticks average SAMPLE_HZ exactly.
  // ---------------------------------------------------------------------------
  assign w_acc_sum   = r_acc + SAMPLE_HZ;
  assign w_tick      = enable && (w_acc_sum >= CLK_HZ);

  assign w_full      = (r_count == DEPTH_W);
  assign w_have_pair = (r_count >= CNT_TWO);
  // flush wins over a same-cycle write, so the word never reaches the RAM.
  assign w_wr_accept = cdda_wr && !w_full && !flush;

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block assigns with <= so all registers sample the same
  // pre-edge values; a blocking = here would make results depend on order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read FSM: next state. A tick outside IDLE cannot occur at legal clock
  // ratios, so RD_L and RD_R advance unconditionally and ignore it.
  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_tick && w_have_pair) w_state_next = RD_L;
      RD_L:    w_state_next = RD_R;
      RD_R:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read FSM: outputs. The left word is read from rd_ptr, the right from
  // rd_ptr+1; since rd_ptr only ever moves by two from zero, rd_ptr[0] = 0
  // always points at a left word and pair alignment cannot slip.
  always_comb begin
    w_ram_re    = 1'b0;
    w_ram_raddr = r_rd_ptr;
    w_pop       = 1'b0;
    w_hold_load = 1'b0;
    w_pair_load = 1'b0;
    w_starve    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          if (w_have_pair) w_ram_re = 1'b1;
          else             w_starve = 1'b1;
        end
      end
      RD_L: begin
        w_ram_re    = 1'b1;
        w_ram_raddr = r_rd_ptr + PTR_ONE;
        w_pop       = 1'b1;
        w_hold_load = 1'b1;
      end
      RD_R: begin
        w_pop       = 1'b1;
        w_pair_load = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pointers, count, divider, output samples and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_hold      <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_sample_ce <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
      r_req       <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_hold      <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_sample_ce <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
      r_req       <= 1'b0;
    end else begin
      if (!enable)     r_acc <= '0;
      else if (w_tick) r_acc <= w_acc_sum - CLK_HZ;
      else             r_acc <= w_acc_sum;

      if (w_wr_accept)        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
      if (cdda_wr && w_full)  r_overflow <= 1'b1;

      unique case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_pair_load) r_rd_ptr <= r_rd_ptr + PTR_TWO;
      if (w_hold_load) r_hold   <= w_ram_rdata;

      // A pair in flight when enable drops still lands; the cycle after,
      // the FSM is back in IDLE and the outputs are forced silent.
      if (w_pair_load) begin
        r_left  <= r_hold;
        r_right <= w_ram_rdata;
      end else if (w_starve || (!enable && (r_state == IDLE))) begin
        r_left  <= '0;
        r_right <= '0;
      end

      r_sample_ce <= w_pair_load || w_starve;
      if (w_starve) r_underrun <= 1'b1;

      r_req <= enable && (32'(DEPTH_W - r_count) >= REQ_WORDS);
    end
  end

  cdda_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (16)
  ) u_ram (
    .clk     (clk_sys),
    .i_we    (w_wr_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (cdda_din),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign cdda_req  = r_req;
  assign left      = r_left;
  assign right     = r_right;
  assign sample_ce = r_sample_ce;
  assign underrun  = r_underrun;
  assign overflow  = r_overflow;
  assign level     = r_count;

endmodule

// File: tb/tb_cdda_fifo.sv
// -----------------------------------------------------------------------------
// tb_cdda_fifo
// Self-checking bench for cdda_fifo. A small configuration (16-word FIFO,
// 10 clocks per sample pair) keeps runs short. Every accepted write is pushed
// to a word queue; each sample_ce pops two words as the expected L/R pair.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cdda_fifo;

  localparam int unsigned CLK_HZ     = 441000;
  localparam int unsigned SAMPLE_HZ  = 44100;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned REQ_WORDS  = 8;
  localparam int          DEPTH      = 16;

  logic                  clk_sys  = 1'b0;
  logic                  reset_n  = 1'b0;
  logic                  enable   = 1'b0;
  logic                  flush    = 1'b0;
  logic                  cdda_wr  = 1'b0;
  logic [15:0]           cdda_din = '0;
  logic                  cdda_req;
  logic [15:0]           left;
  logic [15:0]           right;
  logic                  sample_ce;
  logic                  underrun;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   level;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q [$];

  always #5 clk_sys = ~clk_sys;

  cdda_fifo #(
    .CLK_HZ     (CLK_HZ),
    .SAMPLE_HZ  (SAMPLE_HZ),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .REQ_WORDS  (REQ_WORDS)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .flush     (flush),
    .cdda_wr   (cdda_wr),
    .cdda_din  (cdda_din),
    .cdda_req  (cdda_req),
    .left      (left),
    .right     (right),
    .sample_ce (sample_ce),
    .underrun  (underrun),
    .overflow  (overflow),
    .level     (level)
  );

  // One write strobe; the word is expected only if the FIFO has room.
  // Only called while no pops are in progress, so queue size tracks count.
  task automatic push_write(input logic [15:0] w);
    cdda_wr  = 1'b1;
    cdda_din = w;
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    @(negedge clk_sys);
    cdda_wr  = 1'b0;
  endtask

  task automatic pop_pair(output logic [15:0] el, output logic [15:0] er);
    el = 16'hxxxx;
    er = 16'hxxxx;
    if (exp_q.size() != 0) el = exp_q.pop_front();
    if (exp_q.size() != 0) er = exp_q.pop_front();
  endtask

  task automatic wait_ce(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_sys);
      if (sample_ce === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit seen;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if (cdda_req !== 1'b0 || sample_ce !== 1'b0 || underrun !== 1'b0 || overflow !== 1'b0 ||
        left !== 16'h0 || right !== 16'h0 || level !== '0) begin
      bad++;
      $display("FAIL reset_state: req=%b ce=%b ur=%b ov=%b l=%h r=%h level=%0d, want all zero",
               cdda_req, sample_ce, underrun, overflow, left, right, level);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    enable = 1'b1;
    @(negedge clk_sys);
    total++;
    if (cdda_req !== 1'b1) begin
      bad++;
      $display("FAIL req_after_enable: got %b want 1", cdda_req);
    end
    wait_ce(30, seen);
    total++;
    if (!seen || underrun !== 1'b1 || left !== 16'h0 || right !== 16'h0 || level !== '0) begin
      bad++;
      $display("FAIL empty_tick: seen=%b ur=%b l=%h r=%h level=%0d, want 1 1 0 0 0",
               seen, underrun, left, right, level);
    end
    enable = 1'b0;
    do_flush();
    total++;
    if (underrun !== 1'b0 || cdda_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_clears_underrun: ur=%b req=%b want 0 0", underrun, cdda_req);
    end
  endtask

  task automatic test_single_pair();
    bit seen;
    logic [15:0] el, er;
    push_write(16'h1234);
    push_write(16'hABCD);
    total++;
    if (level !== 5'd2) begin
      bad++;
      $display("FAIL level_two: got %0d want 2", level);
    end
    enable = 1'b1;
    wait_ce(30, seen);
    pop_pair(el, er);
    total++;
    if (!seen || left !== el || right !== er) begin
      bad++;
      $display("FAIL single_pair: seen=%b l=%h r=%h want %h %h", seen, left, right, el, er);
    end
    total++;
    if (level !== '0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL single_pair_after: level=%0d ur=%b want 0 0", level, underrun);
    end
    enable = 1'b0;
    @(negedge clk_sys);
    total++;
    if (left !== 16'h0 || right !== 16'h0 || sample_ce !== 1'b0) begin
      bad++;
      $display("FAIL enable_off_zero: l=%h r=%h ce=%b want 0 0 0", left, right, sample_ce);
    end
  endtask

  task automatic test_odd_residual();
    bit seen;
    logic [15:0] el, er;
    push_write(16'h5555);
    enable = 1'b1;
    wait_ce(30, seen);
    total++;
    if (!seen || underrun !== 1'b1 || left !== 16'h0 || right !== 16'h0 || level !== 5'd1) begin
      bad++;
      $display("FAIL odd_word_kept: seen=%b ur=%b l=%h r=%h level=%0d want 1 1 0 0 1",
               seen, underrun, left, right, level);
    end
    enable = 1'b0;
    push_write(16'h6666);
    enable = 1'b1;
    wait_ce(30, seen);
    pop_pair(el, er);
    total++;
    if (!seen || left !== el || right !== er) begin
      bad++;
      $display("FAIL odd_partner_pair: seen=%b l=%h r=%h want %h %h", seen, left, right, el, er);
    end
    enable = 1'b0;
    do_flush();
  endtask

  task automatic test_rate();
    int sent = 0;
    int pairs = 0;
    int last_ce = -1;
    logic [15:0] el, er, w;
    for (int i = 0; i < 6; i++) begin
      push_write(16'(sent * 7919 + 3));
      sent++;
    end
    enable = 1'b1;
    for (int cyc = 0; cyc < 12000 && pairs < 1000; cyc++) begin
      if (sample_ce === 1'b1) begin
        pop_pair(el, er);
        total++;
        if (left !== el || right !== er) begin
          bad++;
          $display("FAIL rate_pair%0d: l=%h r=%h want %h %h", pairs, left, right, el, er);
        end
        if (last_ce >= 0) begin
          total++;
          if (cyc - last_ce != 10) begin
            bad++;
            $display("FAIL rate_interval%0d: got %0d cycles want 10", pairs, cyc - last_ce);
          end
        end
        last_ce = cyc;
        pairs++;
      end
      if (sent < 2000 && level < 5'd12) begin
        w        = 16'(sent * 7919 + 3);
        cdda_wr  = 1'b1;
        cdda_din = w;
        exp_q.push_back(w);
        sent++;
      end else begin
        cdda_wr = 1'b0;
      end
      @(negedge clk_sys);
    end
    cdda_wr = 1'b0;
    enable  = 1'b0;
    total++;
    if (pairs != 1000) begin
      bad++;
      $display("FAIL rate_pair_count: got %0d want 1000", pairs);
    end
    total++;
    if (underrun !== 1'b0 || overflow !== 1'b0 || level !== '0) begin
      bad++;
      $display("FAIL rate_end_state: ur=%b ov=%b level=%0d want 0 0 0", underrun, overflow, level);
    end
  endtask

  task automatic test_overflow_wrap();
    bit seen;
    logic [15:0] el, er;
    // Move the pointers off zero so the full buffer straddles the wrap.
    push_write(16'h0F0F);
    push_write(16'hF0F0);
    enable = 1'b1;
    wait_ce(30, seen);
    pop_pair(el, er);
    total++;
    if (!seen || left !== el || right !== er) begin
      bad++;
      $display("FAIL wrap_prefix_pair: seen=%b l=%h r=%h want %h %h", seen, left, right, el, er);
    end
    enable = 1'b0;
    for (int i = 1; i <= 17; i++) push_write(16'(16'h0100 + i));
    total++;
    if (level !== 5'd16 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL full_overflow: level=%0d ov=%b want 16 1", level, overflow);
    end
    enable = 1'b1;
    @(negedge clk_sys);
    total++;
    if (cdda_req !== 1'b0) begin
      bad++;
      $display("FAIL req_when_full: got %b want 0", cdda_req);
    end
    for (int p = 0; p < 8; p++) begin
      wait_ce(30, seen);
      pop_pair(el, er);
      total++;
      if (!seen || left !== el || right !== er) begin
        bad++;
        $display("FAIL wrap_pair%0d: seen=%b l=%h r=%h want %h %h", p, seen, left, right, el, er);
        break;
      end
    end
    enable = 1'b0;
    total++;
    if (level !== '0 || overflow !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_end: level=%0d ov=%b left_in_model=%0d want 0 1 0",
               level, overflow, exp_q.size());
    end
    do_flush();
  endtask

  task automatic test_wr_pop_and_flush();
    bit seen;
    logic [15:0] el, er;
    for (int i = 0; i < 8; i++) push_write(16'(16'h2000 + i));
    enable = 1'b1;
    // Tick lands on the 10th edge; the next two edges are the two pops.
    repeat (10) @(negedge clk_sys);
    cdda_wr  = 1'b1;
    cdda_din = 16'h2100;
    exp_q.push_back(16'h2100);
    @(negedge clk_sys);
    total++;
    if (level !== 5'd8) begin
      bad++;
      $display("FAIL wr_pop_rd_l: level=%0d want 8", level);
    end
    cdda_din = 16'h2101;
    exp_q.push_back(16'h2101);
    @(negedge clk_sys);
    cdda_wr = 1'b0;
    enable  = 1'b0;
    pop_pair(el, er);
    total++;
    if (sample_ce !== 1'b1 || level !== 5'd8 || left !== el || right !== er) begin
      bad++;
      $display("FAIL wr_pop_rd_r: ce=%b level=%0d l=%h r=%h want 1 8 %h %h",
               sample_ce, level, left, right, el, er);
    end
    push_write(16'h2222);
    flush    = 1'b1;
    cdda_wr  = 1'b1;
    cdda_din = 16'hDEAD;
    @(negedge clk_sys);
    flush   = 1'b0;
    cdda_wr = 1'b0;
    exp_q.delete();
    total++;
    if (level !== '0 || underrun !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL flush_with_write: level=%0d ur=%b ov=%b want 0 0 0", level, underrun, overflow);
    end
    push_write(16'h1111);
    push_write(16'h7777);
    enable = 1'b1;
    wait_ce(30, seen);
    pop_pair(el, er);
    enable = 1'b0;
    total++;
    if (!seen || left !== el || right !== er) begin
      bad++;
      $display("FAIL after_flush_left_first: seen=%b l=%h r=%h want %h %h",
               seen, left, right, el, er);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    logic [15:0] el, er;
    for (int i = 0; i < 4; i++) push_write(16'(16'h3000 + i));
    enable = 1'b1;
    wait_ce(30, seen);
    pop_pair(el, er);
    total++;
    if (!seen || left !== el || right !== er) begin
      bad++;
      $display("FAIL pre_reset_pair: seen=%b l=%h r=%h want %h %h", seen, left, right, el, er);
    end
    // Next tick is 8 edges on; one edge later the FSM sits in RD_R.
    repeat (9) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    total++;
    if (left !== 16'h0 || right !== 16'h0 || sample_ce !== 1'b0 || level !== '0 || cdda_req !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_outputs: l=%h r=%h ce=%b level=%0d req=%b want all zero",
               left, right, sample_ce, level, cdda_req);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk_sys);
    total++;
    if (cdda_req !== 1'b1 || level !== '0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_release: req=%b level=%0d ur=%b want 1 0 0", cdda_req, level, underrun);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_odd_residual();
    test_rate();
    test_overflow_wrap();
    test_wr_pop_and_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdda_fifo.md
Name: cdda_fifo

Overview:
- Audio consumer sitting directly downstream of the HPS extension decoder's CD-audio write port (cdda_wr / cdda_dout) and driving its cdda_req status bit.
- Buffers interleaved 16-bit little-endian PCM words (L, R, L, R, ...) from the HPS.
- Plays them out as stereo sample pairs at 44.1 kHz into the Paula/audio mixer.
- Requests the next burst from the HPS whenever enough free space exists.

Parameters:
- CLK_HZ, 28375160, clk_sys frequency in Hz (sets the sample-tick divider).
- SAMPLE_HZ, 44100, output sample-pair rate in Hz.
- DEPTH_LOG2, 12, FIFO depth = 2**DEPTH_LOG2 sixteen-bit words.
- REQ_WORDS, 1176, free words required before cdda_req asserts (one 2352-byte CD sector).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  playback enable; 0 = outputs held at zero, no pops, no requests
- flush  in  1  synchronous clear of FIFO contents and flags
- cdda_wr  in  1  one-cycle write strobe from the HPS extension decoder
- cdda_din  in  16  PCM word accompanying cdda_wr
- cdda_req  out  1  more data wanted
- left  out  16  signed left sample
- right  out  16  signed right sample
- sample_ce  out  1  one-cycle pulse when left/right update
- underrun  out  1  sticky: a tick found fewer than 2 words
- overflow  out  1  sticky: a write arrived while full
- level  out  DEPTH_LOG2+1  current word count

Behaviour:
- Reset (async, reset_n=0) values: all outputs 0; rd/wr pointers 0; count 0; divider accumulator 0; state IDLE; parity = left.
- flush (synchronous) has the same effect as reset on pointers, count, flags, accumulator, state, left/right and parity. flush takes priority over a same-cycle cdda_wr, which is dropped.
- Storage is a dual-port RAM, 2**DEPTH_LOG2 x 16, with a registered read (1-cycle latency).
  - Pointers are DEPTH_LOG2 bits and wrap modulo the depth.
  - level = count, range 0..2**DEPTH_LOG2.
- Write: on cdda_wr while count < depth, store cdda_din at wr_ptr and increment wr_ptr.
  - While full, the word is dropped and overflow is set.
  - Writes are accepted regardless of enable.
- Tick generator: 32-bit accumulator.
  - Each cycle with enable=1: acc += SAMPLE_HZ.
  - When acc + SAMPLE_HZ >= CLK_HZ: acc <= acc + SAMPLE_HZ - CLK_HZ and tick=1.
  - enable=0 holds acc at 0.
- Read FSM:
  - IDLE: on tick, if count >= 2 go to RD_L and issue a read at rd_ptr. Otherwise set underrun, zero left/right, pulse sample_ce, and stay in IDLE.
  - RD_L: capture RAM data into a left holding register, issue a read at rd_ptr+1, go to RD_R.
  - RD_R: latch left <= hold and right <= RAM data together, pulse sample_ce, rd_ptr += 2, go to IDLE.
  - Count decrements by 1 in each of RD_L and RD_R.
  - A tick arriving outside IDLE is impossible at legal ratios (CLK_HZ/SAMPLE_HZ > 3); it is ignored.
- Count update when a write and a pop happen in the same cycle: net change is 0.
- Pair alignment: the first word after reset/flush is always left. An odd residual word (count=1) is never consumed until its partner arrives.
- cdda_req = enable & ~flush & (depth - count >= REQ_WORDS), registered (1-cycle lag).
  - The HPS bursts at most REQ_WORDS words per request, so no overflow occurs in correct operation.
- enable falling mid-pair: the FSM completes RD_L/RD_R, then left/right are forced to 0 on the next cycle and sample_ce stops.
- Flags are cleared only by reset or flush.

Decomposition:
- Shared audio package:
  - CDDA state enum (IDLE, RD_L, RD_R).
  - Constants CDDA_SAMPLE_HZ=44100 and CDDA_SECTOR_WORDS=1176.
- One sub-module, cdda_ram: simple dual-port RAM with a registered read, so it infers block RAM.
- Divider and FSM stay in cdda_fifo.

Test Plan:
- Reset then enable=1, no writes → cdda_req=1 after 1 cycle; first tick gives underrun=1, sample_ce pulse, left=right=0; level=0.
- Write 0x1234, 0xABCD, then a tick → sample_ce with left=0x1234, right=0xABCD; level returns to 0; underrun stays 0 if no earlier tick.
- CLK_HZ=441000, SAMPLE_HZ=44100, continuous supply → sample_ce exactly every 10 cycles; 1000 pairs out in 10000 cycles, in FIFO order.
- DEPTH_LOG2=4, write 17 words with no pops → level=16, overflow=1, 17th word lost; playback yields words 1..16 across wrap after refills.
- Write and pop in the same cycle at level=8 → level unchanged; then flush with a same-cycle cdda_wr → level=0, flags 0, next word out is left.
- Assert reset_n=0 in RD_R → outputs 0 immediately (asynchronous); after release the FIFO is empty and cdda_req=1.
